serial_panel_ctrl: RTL and testbench



---
 rtl/serial_panel_ctrl.sv | 85 ++++++++
 tb/tb_serial_panel_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/serial_panel_ctrl.sv
// serial_panel_ctrl: frame sequencer for four lock-step 74LV595/74LV165 chain pairs
module serial_panel_ctrl #(
  parameter int DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [63:0] out_data,
  output logic [63:0] in_data,
  output logic        in_valid,
  output logic        busy,
  output logic        serial_out_srclk,
  output logic        serial_out_rclk,
  output logic        serial_out_ser_0,
  output logic        serial_out_ser_1,
  output logic        serial_out_ser_2,
  output logic        serial_out_ser_3,
  output logic        serial_in_rclk,
  output logic        serial_in_shldn,
  input  logic        serial_in_ser_0,
  input  logic        serial_in_ser_1,
  input  logic        serial_in_ser_2,
  input  logic        serial_in_ser_3
);
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH, DONE} state_t;
  state_t      state, state_n;
  logic [7:0]  phase;
  logic [3:0]  bit_cnt;
  logic [15:0] out_sh [4];
  logic [15:0] in_sh [4];
  logic [3:0]  ser_in;
  logic        last;
  logic        shifting;
  assign last     = phase == 8'(DIV - 1);
  assign ser_in   = {serial_in_ser_3, serial_in_ser_2, serial_in_ser_1, serial_in_ser_0};
  assign shifting = state == SHIFT_LO || state == SHIFT_HI;
  // Pin waveforms decode straight from the state so reset forces them idle at once
  assign busy             = state != IDLE;
  assign in_valid         = state == DONE;
  assign serial_out_srclk = state == SHIFT_HI;
  assign serial_in_rclk   = state == SHIFT_HI;
  assign serial_out_rclk  = state == LATCH;
  assign serial_in_shldn  = state != LOAD;
  assign serial_out_ser_0 = shifting & out_sh[0][15];
  assign serial_out_ser_1 = shifting & out_sh[1][15];
  assign serial_out_ser_2 = shifting & out_sh[2][15];
  assign serial_out_ser_3 = shifting & out_sh[3][15];
  // Next-state: every timed state lasts DIV cycles, DONE lasts one
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = enable ? LOAD : IDLE;
      LOAD:     state_n = last ? SHIFT_LO : LOAD;
      SHIFT_LO: state_n = last ? SHIFT_HI : SHIFT_LO;
      SHIFT_HI: state_n = last ? (bit_cnt == 4'd0 ? LATCH : SHIFT_LO) : SHIFT_HI;
      LATCH:    state_n = last ? DONE : LATCH;
      DONE:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end
  // State, phase/bit counters, shifters and the published switch words
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      phase   <= '0;
      bit_cnt <= '0;
      in_data <= '0;
      for (int k = 0; k < 4; k++) begin
        out_sh[k] <= '0;
        in_sh[k]  <= '0;
      end
    end else begin
      state <= state_n;
      phase <= (state == IDLE || state == DONE || last) ? 8'd0 : phase + 8'd1;
      if (state == LOAD) bit_cnt <= 4'd15;
      else if (state == SHIFT_HI && last) bit_cnt <= bit_cnt - 4'd1;
      for (int k = 0; k < 4; k++) begin
        if (state == IDLE && enable) out_sh[k] <= out_data[16*k +: 16];
        else if (state == SHIFT_HI && last) out_sh[k] <= {out_sh[k][14:0], 1'b0};
        if (state == SHIFT_LO && last) in_sh[k] <= {in_sh[k][14:0], ser_in[k]};
      end
      if (state == LATCH && last) in_data <= {in_sh[3], in_sh[2], in_sh[1], in_sh[0]};
    end
  end
endmodule

// File: tb/tb_serial_panel_ctrl.sv
// tb_serial_panel_ctrl: scoreboard bench with 595/165 chain models on the pins
module tb_serial_panel_ctrl;
  localparam int DIV = 2;
  localparam int FRAME = 34 * DIV + 2;
  typedef struct {logic [63:0] din; logic [63:0] disp;} exp_t;
  logic clk = 1'b0, reset = 1'b1, enable = 1'b0;
  logic [63:0] out_data = '0, in_data, par_w = '0;
  logic in_valid, busy, srclk, rclk, in_rclk, shldn;
  logic [3:0] ser_o, ser_in;
  logic [15:0] sr [4] = '{default: '0};
  logic [15:0] st [4] = '{default: '0};
  logic [15:0] r165 [4] = '{default: '0};
  exp_t q[$];
  int compared = 0, mismatched = 0;
  int pulses = 0, edges = 0, last_pulse = -1, cyc = 0, exp_period = 0;
  int clk_mis = 0, ser_unstable = 0, held_changed = 0;
  logic prev_srclk = 1'b0;
  logic [3:0] prev_ser = '0;
  logic [63:0] held = '0;
  serial_panel_ctrl #(.DIV(DIV)) dut (
    .clk(clk), .reset(reset), .enable(enable), .out_data(out_data),
    .in_data(in_data), .in_valid(in_valid), .busy(busy),
    .serial_out_srclk(srclk), .serial_out_rclk(rclk),
    .serial_out_ser_0(ser_o[0]), .serial_out_ser_1(ser_o[1]),
    .serial_out_ser_2(ser_o[2]), .serial_out_ser_3(ser_o[3]),
    .serial_in_rclk(in_rclk), .serial_in_shldn(shldn),
    .serial_in_ser_0(ser_in[0]), .serial_in_ser_1(ser_in[1]),
    .serial_in_ser_2(ser_in[2]), .serial_in_ser_3(ser_in[3])
  );
  always #5 clk = ~clk;
  // Two-deep 595 chains: shift on SRCLK, copy to storage on RCLK
  always @(posedge srclk) begin
    edges++;
    for (int k = 0; k < 4; k++) sr[k] <= {sr[k][14:0], ser_o[k]};
  end
  always @(posedge rclk) for (int k = 0; k < 4; k++) st[k] <= sr[k];
  // Two-deep 165 chains: parallel word taken as SH/LD_n releases, QH is bit 15
  always @(posedge shldn) for (int k = 0; k < 4; k++) r165[k] <= par_w[16*k +: 16];
  always @(posedge in_rclk) for (int k = 0; k < 4; k++) r165[k] <= {r165[k][14:0], 1'b0};
  assign ser_in = {r165[3][15], r165[2][15], r165[1][15], r165[0][15]};
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  // Monitor: pin-level invariants every cycle, scoreboard pop on each in_valid
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (srclk !== in_rclk) clk_mis++;
    if (srclk && prev_srclk && ser_o !== prev_ser) ser_unstable++;
    prev_srclk = srclk;
    prev_ser = ser_o;
    if (reset || in_valid) held = in_data;
    else if (in_data !== held) held_changed++;
    if (in_valid) begin
      pulses++;
      if (q.size() == 0) check("unexpected_valid", 64'd1, 64'd0);
      else begin
        e = q.pop_front();
        check("in_data", in_data, e.din);
        check("display", {st[3], st[2], st[1], st[0]}, e.disp);
      end
      if (exp_period != 0 && last_pulse >= 0) check("period", 64'(cyc - last_pulse), 64'(exp_period));
      last_pulse = cyc;
    end
  end
  task automatic single_frame(input logic [63:0] o, input logic [63:0] p, input int chg_at, input logic [63:0] chg);
    int lat, p0;
    out_data = o;
    par_w = p;
    q.push_back('{din: p, disp: o});
    p0 = pulses;
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    lat = 1;
    while (!in_valid && lat < 4 * FRAME) begin
      @(negedge clk);
      lat++;
      if (lat == chg_at) out_data = chg;
    end
    check("latency", 64'(lat), 64'(FRAME - 1));
    tick(FRAME);
    check("pulse_count", 64'(pulses - p0), 64'd1);
  endtask
  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction
  initial begin
    int p0, e0;
    logic [63:0] prev_disp, o;
    tick(2);
    check("reset_pins", {busy, in_valid, srclk, rclk, in_rclk, shldn, ser_o}, 10'b0000010000);
    check("reset_in_data", in_data, 64'd0);
    reset = 1'b0;
    tick(2);
    single_frame(64'h8000_FFFF_A5C3_0001, 64'h7FFE_BEEF_0000_1234, 0, '0);
    for (int i = 0; i < 3; i++) single_frame(rnd64(), rnd64(), 0, '0);
    o = rnd64();
    o[15:0] = 16'h00FF;
    single_frame(o, rnd64(), 30, {o[63:16], 16'hFF00});
    single_frame(out_data, rnd64(), 0, '0);
    // Back-to-back frames; new words staged mid-frame for the following frame
    exp_period = FRAME;
    last_pulse = -1;
    p0 = pulses;
    out_data = rnd64();
    par_w = rnd64();
    q.push_back('{din: par_w, disp: out_data});
    enable = 1'b1;
    for (int j = 0; j < 5; j++) begin
      tick(35);
      if (j < 4) begin
        out_data = rnd64();
        par_w = rnd64();
        q.push_back('{din: par_w, disp: out_data});
      end else enable = 1'b0;
      tick(35);
    end
    tick(40);
    check("stream_pulses", 64'(pulses - p0), 64'd5);
    exp_period = 0;
    e0 = edges;
    tick(50);
    check("idle_edges", 64'(edges - e0), 64'd0);
    check("idle_busy", {63'd0, busy}, 64'd0);
    // Abort a frame with reset during the high phase of bit 7
    prev_disp = {st[3], st[2], st[1], st[0]};
    out_data = rnd64();
    par_w = rnd64();
    enable = 1'b1;
    tick(1);
    enable = 1'b0;
    tick(36);
    #2 reset = 1'b1;
    #1;
    check("abort_pins", {busy, in_valid, srclk, rclk, in_rclk, shldn, ser_o}, 10'b0000010000);
    check("abort_in_data", in_data, 64'd0);
    tick(5);
    check("abort_display", {st[3], st[2], st[1], st[0]}, prev_disp);
    reset = 1'b0;
    tick(2);
    single_frame(rnd64(), rnd64(), 0, '0);
    check("clk_match", 64'(clk_mis), 64'd0);
    check("ser_stable", 64'(ser_unstable), 64'd0);
    check("in_data_hold", 64'(held_changed), 64'd0);
    check("queue_empty", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
